// File: rtl/ej32_pkg.sv
// Shared eJ32 ALU definitions: datapath widths and the multiplier FSM state type.
//   DU        default data width
//   DU2       double data width (product width)
//   U1        single-bit width
//   MUL_CNT_W iteration counter width for the default data width
package ej32_pkg;

  localparam int unsigned DU        = 32;
  localparam int unsigned DU2       = 2 * DU;
  localparam int unsigned U1        = 1;
  localparam int unsigned MUL_CNT_W = $clog2(DU);

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_st_t;

endpackage

// File: rtl/mul_step.sv
// One radix-2 shift-add iteration (combinational).
//   acc, m, q   current accumulator, shifted multiplicand, remaining multiplier
//   acc_n       acc + m when q[0] is set, else acc
//   m_n, q_n    multiplicand shifted left, multiplier shifted right
//   qz          no multiplier bits remain after this step
module mul_step
  import ej32_pkg::*;
#(
  parameter int unsigned DSZ = DU
) (
  input  logic [2*DSZ-1:0] acc,
  input  logic [2*DSZ-1:0] m,
  input  logic [DSZ-1:0]   q,
  output logic [2*DSZ-1:0] acc_n,
  output logic [2*DSZ-1:0] m_n,
  output logic [DSZ-1:0]   q_n,
  output logic             qz
);

  // m only holds a DSZ-bit value shifted at most DSZ-1 places, so the sum fits.
  always_comb begin
    acc_n = q[0] ? (acc + m) : acc;
    m_n   = m << 1;
    q_n   = q >> 1;
    qz    = (q_n == '0);
  end

endmodule

// File: rtl/mul_int.sv
// Sequential radix-2 shift-add unsigned multiplier, DSZ x DSZ -> 2*DSZ.
//   clk    clock
//   rst    asynchronous active-low reset
//   start  load x,y and begin (ignored while busy)
//   x, y   multiplicand / multiplier, sampled on accepted start
//   busy   iteration in progress
//   done   one-cycle pulse, p holds a new result
//   p      product, held until the next done
// Build option: define MUL_EARLY_EN to leave RUN as soon as no multiplier bits
// remain; otherwise the operation always takes DSZ RUN cycles.
module mul_int
  import ej32_pkg::*;
#(
  parameter int unsigned DSZ = DU
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DSZ-1:0]   x,
  input  logic [DSZ-1:0]   y,
  output logic             busy,
  output logic             done,
  output logic [2*DSZ-1:0] p
);

  localparam int unsigned PW = 2 * DSZ;
  localparam int unsigned CW = (DSZ > 1) ? $clog2(DSZ) : 1;

`ifdef MUL_EARLY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  mul_st_t         state, state_n;
  logic [PW-1:0]   m, acc;
  logic [DSZ-1:0]  q;
  logic [CW-1:0]   i;

  logic [PW-1:0]   acc_n, m_n;
  logic [DSZ-1:0]  q_n;
  logic            qz;

  logic            load, step, last;

  mul_step #(.DSZ(DSZ)) u_step (
    .acc   (acc),
    .m     (m),
    .q     (q),
    .acc_n (acc_n),
    .m_n   (m_n),
    .q_n   (q_n),
    .qz    (qz)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MUL_IDLE;
    else      state <= state_n;
  end

  // Next state and datapath controls; DONE accepts a new start since busy is low.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state)
      MUL_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = MUL_RUN;
        end
      end
      MUL_RUN: begin
        step = 1'b1;
        if ((i == '0) || (EARLY && qz)) begin
          last    = 1'b1;
          state_n = MUL_DONE;
        end
      end
      MUL_DONE: begin
        state_n = MUL_IDLE;
        if (start) begin
          load    = 1'b1;
          state_n = MUL_RUN;
        end
      end
      default: state_n = MUL_IDLE;
    endcase
  end

  // Iteration registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m   <= '0;
      q   <= '0;
      acc <= '0;
      i   <= '0;
    end else if (load) begin
      m   <= PW'(x);
      q   <= y;
      acc <= '0;
      i   <= CW'(DSZ - 1);
    end else if (step) begin
      m   <= m_n;
      q   <= q_n;
      acc <= acc_n;
      i   <= i - CW'(1);
    end
  end

  // Registered status/result; flags follow the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      p    <= '0;
    end else begin
      busy <= (state_n == MUL_RUN);
      done <= (state_n == MUL_DONE);
      if (last) p <= acc_n;
    end
  end

endmodule

// File: tb/tb_mul_int.sv
// Directed bench for mul_int (DSZ=32) with a product scoreboard.
module tb_mul_int;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] x;
  logic [31:0] y;
  logic        busy;
  logic        done;
  logic [63:0] p;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  mul_int #(.DSZ(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RUN cycles expected for multiplier b.
  function automatic int exp_lat(input logic [31:0] b);
`ifdef MUL_EARLY_EN
    int h;
    h = 0;
    for (int j = 0; j < 32; j++) if (b[j]) h = j + 1;
    return (h == 0) ? 1 : h;
`else
    return 32;
`endif
  endfunction

  // Every done pulse must match the oldest outstanding product.
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL stray_done: observed done=1 expected no outstanding op");
      end
      if (sb.size() > 0) begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("product", p, e);
      end
    end
  end

  // Called in cycle k0 of an operation; returns in its done cycle (or on timeout).
  task automatic wait_done(input string tag, input int lat, input int k0);
    int  k;
    bit  seen;
    k    = k0;
    seen = 1'b0;
    while (!seen && k <= lat + 4) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        if (k <= lat) chk({tag, "_busy"}, 64'(busy), 64'd1);
        tick();
        k++;
      end
    end
    chk({tag, "_done_cycle"}, 64'(k), 64'(lat + 1));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] prod);
    x     = a;
    y     = b;
    start = 1'b1;
    sb.push_back(prod);
    tick();
    start = 1'b0;
    wait_done(tag, exp_lat(b), 1);
    tick();
    chk({tag, "_p_hold"}, p, prod);
    chk({tag, "_done_low"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat;
    int c;
    int n_done;
    logic [31:0] ra, rb;

    rst   = 1'b0;
    start = 1'b0;
    x     = '0;
    y     = '0;
    repeat (3) tick();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_p", p, 64'd0);
    rst = 1'b1;
    tick();

    run_op("mul_3x5", 32'd3, 32'd5, 64'd15);
    run_op("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("mul_y0", 32'h1234_5678, 32'd0, 64'd0);
    run_op("mul_x0", 32'd0, 32'hDEAD_BEEF, 64'd0);
    run_op("mul_pow2", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    for (int r = 0; r < 4; r++) begin
      ra = $urandom();
      rb = $urandom();
      run_op("mul_rand", ra, rb, 64'(ra) * 64'(rb));
    end

    // Start while busy is ignored.
    x     = 32'd3;
    y     = 32'd5;
    start = 1'b1;
    sb.push_back(64'd15);
    tick();
    start = 1'b0;
    lat   = exp_lat(32'd5);
    c     = (lat >= 5) ? 5 : 2;
    for (int k = 1; k < c; k++) tick();
    x     = 32'd7;
    y     = 32'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_start", lat, c + 1);
    tick();
    chk("busy_start_p_hold", p, 64'd15);

    // Start in the DONE cycle is accepted back-to-back.
    x     = 32'd3;
    y     = 32'd5;
    start = 1'b1;
    sb.push_back(64'd15);
    tick();
    start = 1'b0;
    wait_done("b2b_first", exp_lat(32'd5), 1);
    chk("b2b_first_p", p, 64'd15);
    x     = 32'd2;
    y     = 32'd3;
    start = 1'b1;
    sb.push_back(64'd6);
    tick();
    start = 1'b0;
    chk("b2b_busy_next", 64'(busy), 64'd1);
    chk("b2b_done_next", 64'(done), 64'd0);
    chk("b2b_p_old", p, 64'd15);
    wait_done("b2b_second", exp_lat(32'd3), 1);
    tick();
    chk("b2b_p_new", p, 64'd6);

    // Reset in the middle of RUN aborts without a done pulse.
    x     = 32'hFFFF_0000;
    y     = 32'hFFFF_FFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    sb.delete();
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_p", p, 64'd0);
    repeat (3) tick();
    chk("abort_busy_hold", 64'(busy), 64'd0);
    chk("abort_p_hold", p, 64'd0);
    rst    = 1'b1;
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    chk("abort_no_done", 64'(n_done), 64'd0);
    chk("abort_idle_busy", 64'(busy), 64'd0);

    run_op("post_reset", 32'd3, 32'd5, 64'd15);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
